// File: rtl/slave_sda_generate_if.sv
// -----------------------------------------------------------------------------
// slave_sda_generate_if
//
// Application-side signals of the I2C slave engine. The I2C pins (scl, sda)
// stay plain ports on the slave so the open-drain SDA net resolves normally.
//
// Handshake semantics: there is no valid/ready pair on this interface. All
// signals are levels. receive_dataN_ack and dataN_received are sampled by the
// slave at the moment it needs them (8th SCL fall of write byte N, first bit
// of read byte N). data1_sent/data2_sent update once, at the 8th SCL fall of
// the corresponding write byte, and otherwise hold.
//
// Signals
//   receive_data1_ack  ACK level for write byte 1 (0 = ACK, 1 = NACK)
//   receive_data2_ack  ACK level for write byte 2
//   data1_received     read byte 1 returned to the master
//   data2_received     read byte 2 returned to the master
//   data1_sent         write byte 1 captured from the master
//   data2_sent         write byte 2 captured from the master
//   state_dbg          current protocol state (debug observation only)
// -----------------------------------------------------------------------------
interface slave_sda_generate_if;
  logic       receive_data1_ack;
  logic       receive_data2_ack;
  logic [7:0] data1_received;
  logic [7:0] data2_received;
  logic [7:0] data1_sent;
  logic [7:0] data2_sent;
  logic [2:0] state_dbg;

  modport slave (
    input  receive_data1_ack,
    input  receive_data2_ack,
    input  data1_received,
    input  data2_received,
    output data1_sent,
    output data2_sent,
    output state_dbg
  );

  modport master (
    output receive_data1_ack,
    output receive_data2_ack,
    output data1_received,
    output data2_received,
    input  data1_sent,
    input  data2_sent,
    input  state_dbg
  );
endinterface

// File: rtl/slave_sda_generate.sv
// -----------------------------------------------------------------------------
// slave_sda_generate
//
// I2C slave protocol engine on an oversampled SCL/SDA pair. Detects START and
// STOP, matches a 7-bit address, accepts two write bytes or returns two read
// bytes. SDA is driven open-drain (0 or z) only in ACK slots and read bits.
//
// Ports
//   clk    system clock, at least 8x the SCL frequency
//   rst_n  synchronous active-low reset
//   scl    I2C clock from the master (asynchronous to clk)
//   sda    I2C data, open-drain, externally pulled up
//   bus    application-side data, ACK control and debug state
//
// State encoding on bus.state_dbg:
//   0 IDLE, 1 ADDR, 2 ADDR_ACK, 3 WR_DATA, 4 WR_ACK, 5 RD_DATA, 6 RD_ACK,
//   7 WAIT_STOP
// -----------------------------------------------------------------------------
module slave_sda_generate #(
  parameter logic [6:0] SLAVE_ADDR = 7'h5B
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 scl,
  inout  wire                  sda,
  slave_sda_generate_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ADDR      = 3'd1,
    ADDR_ACK  = 3'd2,
    WR_DATA   = 3'd3,
    WR_ACK    = 3'd4,
    RD_DATA   = 3'd5,
    RD_ACK    = 3'd6,
    WAIT_STOP = 3'd7
  } state_t;

  state_t     state;
  logic       scl_s1, scl_s2, scl_d;
  logic       sda_s1, sda_s2, sda_d;
  logic [3:0] address_counter;
  logic [7:0] shift_reg;     // incoming bits (address or write data)
  logic [7:0] tx_reg;        // outgoing read byte, bit 7 is on the wire
  logic       rw_bit;
  logic       byte_sel;      // 0 = byte index 1, 1 = byte index 2
  logic       master_ack;
  logic       drive_low;

  logic scl_rise, scl_fall, sda_rise, sda_fall, start_cond, stop_cond;

  // Edges come from the second sync flop against its delayed copy, so an
  // action lands 3 clk after the pin change.
  assign scl_rise   = scl_s2 & ~scl_d;
  assign scl_fall   = ~scl_s2 & scl_d;
  assign sda_rise   = sda_s2 & ~sda_d;
  assign sda_fall   = ~sda_s2 & sda_d;
  assign start_cond = sda_fall & scl_s2;
  assign stop_cond  = sda_rise & scl_s2;

  assign sda           = drive_low ? 1'b0 : 1'bz;
  assign bus.state_dbg = state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // Sync flops reset to the idle bus level so release of reset never
      // fabricates a START/STOP edge.
      scl_s1          <= 1'b1;
      scl_s2          <= 1'b1;
      scl_d           <= 1'b1;
      sda_s1          <= 1'b1;
      sda_s2          <= 1'b1;
      sda_d           <= 1'b1;
      state           <= IDLE;
      address_counter <= 4'd0;
      shift_reg       <= 8'h00;
      tx_reg          <= 8'h00;
      rw_bit          <= 1'b0;
      byte_sel        <= 1'b0;
      master_ack      <= 1'b0;
      drive_low       <= 1'b0;
      bus.data1_sent  <= 8'h00;
      bus.data2_sent  <= 8'h00;
    end else begin
      scl_s1 <= scl;
      scl_s2 <= scl_s1;
      scl_d  <= scl_s2;
      sda_s1 <= sda;
      sda_s2 <= sda_s1;
      sda_d  <= sda_s2;

      // START/STOP win over any SCL edge seen in the same clk.
      if (start_cond) begin
        state           <= ADDR;
        address_counter <= 4'd0;
        drive_low       <= 1'b0;
      end else if (stop_cond) begin
        state     <= IDLE;
        drive_low <= 1'b0;
      end else begin
        case (state)
          ADDR: begin
            if (scl_rise) begin
              shift_reg       <= {shift_reg[6:0], sda_s2};
              address_counter <= address_counter + 4'd1;
            end else if (scl_fall && address_counter == 4'd8) begin
              address_counter <= 4'd0;
              rw_bit          <= shift_reg[0];
              if (shift_reg[7:1] == SLAVE_ADDR) begin
                state     <= ADDR_ACK;
                drive_low <= 1'b1;
              end else begin
                state     <= WAIT_STOP;
                drive_low <= 1'b0;
              end
            end
          end

          ADDR_ACK: begin
            if (scl_fall) begin
              byte_sel <= 1'b0;
              if (rw_bit) begin
                // First read bit goes out on the same fall that ends the ACK.
                state     <= RD_DATA;
                tx_reg    <= bus.data1_received;
                drive_low <= ~bus.data1_received[7];
              end else begin
                state     <= WR_DATA;
                drive_low <= 1'b0;
              end
            end
          end

          WR_DATA: begin
            if (scl_rise) begin
              shift_reg       <= {shift_reg[6:0], sda_s2};
              address_counter <= address_counter + 4'd1;
            end else if (scl_fall && address_counter == 4'd8) begin
              address_counter <= 4'd0;
              state           <= WR_ACK;
              if (!byte_sel) begin
                bus.data1_sent <= shift_reg;
                drive_low      <= ~bus.receive_data1_ack;
              end else begin
                bus.data2_sent <= shift_reg;
                drive_low      <= ~bus.receive_data2_ack;
              end
            end
          end

          WR_ACK: begin
            if (scl_fall) begin
              drive_low <= 1'b0;
              if (!byte_sel) begin
                state    <= WR_DATA;
                byte_sel <= 1'b1;
              end else begin
                state <= WAIT_STOP;
              end
            end
          end

          RD_DATA: begin
            if (scl_rise) begin
              address_counter <= address_counter + 4'd1;
            end else if (scl_fall) begin
              if (address_counter == 4'd8) begin
                address_counter <= 4'd0;
                drive_low       <= 1'b0;
                master_ack      <= 1'b0;
                state           <= RD_ACK;
              end else begin
                tx_reg    <= {tx_reg[6:0], 1'b0};
                drive_low <= ~tx_reg[6];
              end
            end
          end

          RD_ACK: begin
            if (scl_rise) begin
              master_ack <= ~sda_s2;
            end else if (scl_fall) begin
              if (master_ack && !byte_sel) begin
                state     <= RD_DATA;
                byte_sel  <= 1'b1;
                tx_reg    <= bus.data2_received;
                drive_low <= ~bus.data2_received[7];
              end else begin
                state     <= WAIT_STOP;
                drive_low <= 1'b0;
              end
            end
          end

          default: begin
            // IDLE and WAIT_STOP: bus released, only START/STOP matter.
            drive_low <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_slave_sda_generate.sv
// -----------------------------------------------------------------------------
// tb_slave_sda_generate
//
// Bit-banged I2C master around slave_sda_generate. A table of transactions is
// applied in a loop; the repeated-START and reset-mid-read cases are written
// out by hand. Expected ACK levels and read bytes go into exp_q when a byte is
// driven and are popped when the slot is sampled on the wire.
// -----------------------------------------------------------------------------
module tb_slave_sda_generate;

  localparam int Q = 8;  // clk cycles per SCL quarter-phase

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic scl_drv = 1'b1;
  logic master_low = 1'b0;
  wire  sda;

  slave_sda_generate_if bus ();

  assign sda = master_low ? 1'b0 : 1'bz;
  pullup (sda);

  slave_sda_generate #(.SLAVE_ADDR(7'h5B)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .scl   (scl_drv),
    .sda   (sda),
    .bus   (bus)
  );

  // ---------------------------------------------------------------- clock
  always #5 clk = ~clk;

  initial begin
    #(400000 * 10);
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Cycles where SDA is low without the master pulling it: slave drive.
  int pull_cnt = 0;
  always @(negedge clk) if (sda === 1'b0 && !master_low) pull_cnt++;

  // ----------------------------------------------------------- scoreboard
  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic sb_check(input string name, input logic [7:0] act);
    logic [7:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s: got %0h expected <empty queue>", name, act);
    end else begin
      e = exp_q.pop_front();
      check(name, {24'd0, act}, {24'd0, e});
    end
  endtask

  // --------------------------------------------------------- driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic i2c_start();
    master_low = 1'b0;
    tick(Q);
    scl_drv = 1'b1;
    tick(Q);
    master_low = 1'b1;
    tick(Q);
    scl_drv = 1'b0;
    tick(Q);
  endtask

  task automatic i2c_stop();
    master_low = 1'b1;
    tick(Q);
    scl_drv = 1'b1;
    tick(Q);
    master_low = 1'b0;
    tick(Q);
  endtask

  // One SCL pulse; returns the SDA level sampled mid-high.
  task automatic clock_bit(output logic v);
    tick(Q);
    scl_drv = 1'b1;
    tick(Q);
    v = sda;
    tick(Q);
    scl_drv = 1'b0;
    tick(2);
  endtask

  task automatic write_byte(input logic [7:0] b, input logic exp_ack, input string name);
    logic v;
    exp_q.push_back({7'd0, exp_ack});
    for (int i = 7; i >= 0; i--) begin
      master_low = ~b[i];
      clock_bit(v);
    end
    master_low = 1'b0;
    clock_bit(v);
    sb_check(name, {7'd0, v});
  endtask

  task automatic read_byte(input logic [7:0] exp, input logic mack, input string name);
    logic [7:0] got;
    logic v;
    exp_q.push_back(exp);
    master_low = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(v);
      got[i] = v;
    end
    master_low = ~mack;
    clock_bit(v);
    master_low = 1'b0;
    sb_check(name, got);
  endtask

  // ---------------------------------------------------------------- table
  typedef struct {
    logic       is_read;
    logic [6:0] addr;
    logic [7:0] b1;     // write byte 1, or data1_received for a read
    logic [7:0] b2;     // write byte 2, or data2_received for a read
    logic       ack1;
    logic       ack2;
    logic       mack1;  // master's response to read byte 1
    logic [7:0] exp1;
    logic [7:0] exp2;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic       match;
    int         pull_base;
    logic [7:0] r1, r2;
    logic       ra1, ra2;

    r1  = 8'($urandom_range(0, 255));
    r2  = 8'($urandom_range(0, 255));
    ra1 = 1'($urandom_range(0, 1));
    ra2 = 1'($urandom_range(0, 1));
    vecs[0] = '{1'b0, 7'h5B, 8'h4C, 8'h49, 1'b0, 1'b1, 1'b0, 8'h4C, 8'h49};
    vecs[1] = '{1'b0, 7'h22, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0, 8'h4C, 8'h49};
    vecs[2] = '{1'b1, 7'h5B, 8'hA5, 8'h3C, 1'b0, 1'b0, 1'b0, 8'h4C, 8'h49};
    vecs[3] = '{1'b1, 7'h5B, 8'h5A, 8'hC3, 1'b0, 1'b0, 1'b1, 8'h4C, 8'h49};
    vecs[4] = '{1'b0, 7'h5B, r1,    r2,    ra1,  ra2,  1'b0, r1,    r2};

    bus.receive_data1_ack = 1'b0;
    bus.receive_data2_ack = 1'b0;
    bus.data1_received    = 8'h00;
    bus.data2_received    = 8'h00;

    // ------------------------------------------------------ reset block
    rst_n = 1'b0;
    tick(4);
    check("reset_state", {29'd0, bus.state_dbg}, 32'd0);
    check("reset_data1_sent", {24'd0, bus.data1_sent}, 32'h00);
    check("reset_data2_sent", {24'd0, bus.data2_sent}, 32'h00);
    check("reset_sda", {31'd0, sda}, 32'd1);
    rst_n = 1'b1;
    tick(4);

    // ------------------------------------------------------ table loop
    for (int i = 0; i < 5; i++) begin
      match     = (vecs[i].addr == 7'h5B);
      pull_base = pull_cnt;
      bus.receive_data1_ack = vecs[i].ack1;
      bus.receive_data2_ack = vecs[i].ack2;
      bus.data1_received    = vecs[i].is_read ? vecs[i].b1 : 8'h00;
      bus.data2_received    = vecs[i].is_read ? vecs[i].b2 : 8'h00;
      i2c_start();
      write_byte({vecs[i].addr, vecs[i].is_read}, ~match, "addr_ack");
      if (!vecs[i].is_read) begin
        write_byte(vecs[i].b1, match ? vecs[i].ack1 : 1'b1, "wr1_ack");
        write_byte(vecs[i].b2, match ? vecs[i].ack2 : 1'b1, "wr2_ack");
      end else begin
        read_byte(vecs[i].b1, vecs[i].mack1, "rd1_data");
        if (!vecs[i].mack1) read_byte(vecs[i].b2, 1'b1, "rd2_data");
        else read_byte(8'hFF, 1'b1, "rd_after_nack");
        tick(Q);
        check("rd_sda_released", {31'd0, sda}, 32'd1);
      end
      i2c_stop();
      tick(4);
      check("vec_data1_sent", {24'd0, bus.data1_sent}, {24'd0, vecs[i].exp1});
      check("vec_data2_sent", {24'd0, bus.data2_sent}, {24'd0, vecs[i].exp2});
      check("vec_state_idle", {29'd0, bus.state_dbg}, 32'd0);
      if (!match) check("mismatch_no_drive", pull_cnt, pull_base);
    end

    // ------------------------------------------------ repeated START
    bus.receive_data1_ack = 1'b0;
    bus.receive_data2_ack = 1'b0;
    i2c_start();
    write_byte({7'h5B, 1'b0}, 1'b0, "rs_addr1_ack");
    write_byte(8'h11, 1'b0, "rs_byte11_ack");
    check("rs_data1_first", {24'd0, bus.data1_sent}, 32'h11);
    i2c_start();
    write_byte({7'h5B, 1'b0}, 1'b0, "rs_addr2_ack");
    write_byte(8'h77, 1'b0, "rs_byte77_ack");
    write_byte(8'h88, 1'b0, "rs_byte88_ack");
    write_byte(8'h99, 1'b1, "rs_extra_nack");
    i2c_stop();
    tick(4);
    check("rs_data1_sent", {24'd0, bus.data1_sent}, 32'h77);
    check("rs_data2_sent", {24'd0, bus.data2_sent}, 32'h88);

    // ------------------------------------------------ reset mid-read
    bus.data1_received = 8'hA5;
    i2c_start();
    write_byte({7'h5B, 1'b1}, 1'b0, "mr_addr_ack");
    begin
      logic v;
      master_low = 1'b0;
      for (int k = 0; k < 4; k++) clock_bit(v);  // bits 7..4 of 0xA5
    end
    tick(Q);
    check("mr_bit3_driven", {31'd0, sda}, 32'd0);  // bit 3 of 0xA5 is 0
    rst_n = 1'b0;
    tick(1);
    check("mr_sda_release", {31'd0, sda}, 32'd1);
    check("mr_data1_sent", {24'd0, bus.data1_sent}, 32'h00);
    check("mr_data2_sent", {24'd0, bus.data2_sent}, 32'h00);
    check("mr_state_idle", {29'd0, bus.state_dbg}, 32'd0);
    tick(2);
    rst_n = 1'b1;
    tick(2);
    scl_drv = 1'b1;
    tick(Q);

    // Slave must resume on a fresh START.
    i2c_start();
    write_byte({7'h5B, 1'b0}, 1'b0, "post_rst_addr_ack");
    write_byte(8'h12, 1'b0, "post_rst_b1_ack");
    write_byte(8'h34, 1'b0, "post_rst_b2_ack");
    i2c_stop();
    tick(4);
    check("post_rst_data1", {24'd0, bus.data1_sent}, 32'h12);
    check("post_rst_data2", {24'd0, bus.data2_sent}, 32'h34);
    check("scoreboard_drained", exp_q.size(), 0);

    // ------------------------------------------------------ report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/slave_sda_generate.md
# slave_sda_generate

I2C slave data-path and protocol engine for the I2C master test environment. It detects START/STOP on an oversampled SCL/SDA pair and matches a 7-bit address. On a write it accepts two bytes from the master; on a read it returns two bytes. It drives SDA open-drain only during ACK slots and read data bits.

## Interface
- SLAVE_ADDR, 7'h5B, 7-bit address this slave answers to.
- clk  input  1  system clock; frequency must be at least 8x the SCL frequency.
- rst_n  input  1  synchronous, active-low reset.
- scl  input  1  I2C clock from the master, asynchronous to clk.
- sda  inout  1  I2C data line, open-drain, externally pulled up. The slave drives only 1'b0 or 1'bz.
- receive_data1_ack  input  1  ACK level after write byte 1: 0 = pull SDA low (ACK), 1 = release (NACK).
- receive_data2_ack  input  1  same as above, for write byte 2.
- data1_received  input  8  byte returned to the master as read byte 1.
- data2_received  input  8  byte returned to the master as read byte 2.
- data1_sent  output  8  write byte 1 captured from the master.
- data2_sent  output  8  write byte 2 captured from the master.

## Operation
- Synchronize scl and sda through 2 flops each. Derive scl_rise, scl_fall and sda_rise, sda_fall from the synchronized values.
- START: sda_fall while synced scl = 1. Valid in any state, including as a repeated START.
  - Enter ADDR.
  - Clear bit counter address_counter (4-bit).
  - Release SDA.
- STOP: sda_rise while synced scl = 1. Valid in any state.
  - Enter IDLE.
  - Release SDA.
- Bits are sampled MSB first on scl_rise. address_counter increments on every scl_rise within a byte and clears after each ACK slot.
- States and transitions:
  - IDLE: SDA released; wait for START.
  - ADDR: shift 8 bits (7 address + R/W). On the 8th scl_fall:
    - match → ADDR_ACK, drive SDA low;
    - mismatch → WAIT_STOP, SDA released.
  - ADDR_ACK: on the next scl_fall, release SDA.
    - R/W = 0 → WR_DATA (byte index 1).
    - R/W = 1 → RD_DATA; place data1_received[7] on SDA in the same clk.
  - WR_DATA: shift 8 bits.
    - On the 8th scl_fall, load data1_sent (index 1) or data2_sent (index 2).
    - Drive SDA low if the corresponding receive_dataN_ack = 0; otherwise release. Go to WR_ACK.
  - WR_ACK: on scl_fall, release SDA.
    - Index 1 → WR_DATA (index 2).
    - Index 2 → WAIT_STOP. Further write bytes are ignored and NACKed.
  - RD_DATA: drive the current byte bit-by-bit, changing SDA only on scl_fall. A 1 bit means released, a 0 bit means driven low. After the 8th scl_fall, release SDA → RD_ACK.
  - RD_ACK: sample master ACK on scl_rise.
    - If ACK (0) and index 1: on scl_fall, load data2_received, drive bit 7 → RD_DATA (index 2).
    - Otherwise → WAIT_STOP.
  - WAIT_STOP: SDA released; wait for STOP or START.
- data1_sent and data2_sent hold their values until overwritten by a later write transfer. They are not cleared by START or STOP.
- data1_received and data2_received are captured into the shift register when their first bit is driven. Later changes to the inputs do not affect a byte already in flight.

## Timing
- Reset (rst_n = 0 at a clk edge):
  - state = IDLE;
  - address_counter = 0;
  - data1_sent = data2_sent = 8'h00;
  - byte index = 1;
  - SDA released (z).
  - Reset mid-transfer aborts immediately; the slave resumes only on a fresh START.
- Edge detection latency: 3 clk from a pin change (2 sync + 1 register).
- An SDA drive change occurs within 3 clk after the SCL falling edge on the pin. It never changes while SCL is high, except for the release on START/STOP.
- ACK drive spans from the 8th SCL fall to the 9th SCL fall of a byte.
- If a START/STOP edge coincides with an scl edge in the same clk, the START/STOP takes priority.

## Test plan
- Write, address match: START, 0x5B+W, slave ACK; byte 0x4C with receive_data1_ack = 0; byte 0x49 with receive_data2_ack = 1; STOP.
  - Expected: SDA low in the address ACK slot and the byte-1 ACK slot; SDA high in the byte-2 ACK slot.
  - Expected: data1_sent = 0x4C, data2_sent = 0x49; state IDLE after STOP.
- Address mismatch: START, 0x22+W, then a data byte 0xFF.
  - Expected: SDA never driven; data1_sent and data2_sent unchanged.
- Read: START, 0x5B+R, with data1_received = 0xA5, data2_received = 0x3C.
  - Expected: slave ACKs the address, then sends 0xA5.
  - Master ACKs → slave sends 0x3C; master NACKs, then STOP.
  - Expected: SDA released after the final byte.
- Read with early NACK: the master NACKs byte 1.
  - Expected: the slave releases SDA and sends no second byte; the next START is accepted.
- Repeated START: after a write of byte 1 = 0x11, issue a repeated START with 0x5B+W, then write 0x77, 0x88.
  - Expected: data1_sent = 0x77, data2_sent = 0x88.
- Reset mid-read: assert rst_n = 0 during bit 3 of a read.
  - Expected: SDA goes z at the next clk; outputs 8'h00; state IDLE.
